// File: rtl/fpm_mant_mul_seq_if.sv
// Operand/result handshake bundle for the iterative FP mantissa multiply stage.
// Upstream/downstream side uses master; the multiply stage uses slave.
interface fpm_mant_mul_seq_if #(
    parameter int unsigned MW = 24,
    parameter int unsigned EW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic          sign_a;
    logic          sign_b;
    logic [EW-1:0] exp_a;
    logic [EW-1:0] exp_b;
    logic [MW-1:0] man_a;
    logic [MW-1:0] man_b;
    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic [EW-1:0] out_exp;
    logic [MW-2:0] out_man;
    logic          out_ovf;
    logic          out_unf;
    logic          busy;

    modport master (
        output in_valid, sign_a, sign_b, exp_a, exp_b, man_a, man_b, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_man, out_ovf, out_unf, busy
    );

    modport slave (
        input  in_valid, sign_a, sign_b, exp_a, exp_b, man_a, man_b, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_man, out_ovf, out_unf, busy
    );
endinterface

// File: rtl/fpm_mant_mul_seq.sv
// Iterative shift-add mantissa multiplier with exponent rebias, normalisation
// (truncating) and overflow/underflow/zero handling, one product bit per clock.
module fpm_mant_mul_seq #(
    parameter int unsigned MW   = 24,
    parameter int unsigned EW   = 8,
    parameter int unsigned BIAS = 127
) (
    input logic              clk,
    input logic              rst,
    fpm_mant_mul_seq_if.slave bus
);
    localparam int unsigned PW = 2 * MW;
    localparam int unsigned SW = EW + 2;
    localparam int unsigned CW = $clog2(MW);
    localparam logic signed [SW-1:0] EXP_MAX = SW'((2 ** EW) - 1);
    localparam logic [CW-1:0]        LAST_STEP = CW'(MW - 1);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t                state;
    logic [MW-1:0]         mcand;
    logic [PW-1:0]         prod;
    logic [CW-1:0]         cnt;
    logic signed [SW-1:0]  exp_sum;
    logic                  sign_r;
    logic                  zero_r;

    logic [MW:0]           upper_c;
    logic signed [SW-1:0]  exp_in_c;
    logic signed [SW-1:0]  exp_norm_c;
    logic [MW-2:0]         man_norm_c;
    logic                  ovf_c;
    logic                  unf_c;

    // Lower product half doubles as the multiplier: its LSB selects the add,
    // and it drains out as the product shifts in from the top.
    assign upper_c    = {1'b0, prod[PW-1:MW]} + (prod[0] ? {1'b0, mcand} : '0);
    assign exp_in_c   = $signed(SW'(bus.exp_a) + SW'(bus.exp_b) - SW'(BIAS));
    assign exp_norm_c = exp_sum + $signed(SW'(prod[PW-1]));
    assign man_norm_c = prod[PW-1] ? prod[PW-2:MW] : prod[PW-3:MW-1];
    assign ovf_c      = (exp_norm_c >= EXP_MAX);
    assign unf_c      = exp_norm_c[SW-1] || (exp_norm_c == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            mcand         <= '0;
            prod          <= '0;
            cnt           <= '0;
            exp_sum       <= '0;
            sign_r        <= 1'b0;
            zero_r        <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_sign  <= 1'b0;
            bus.out_exp   <= '0;
            bus.out_man   <= '0;
            bus.out_ovf   <= 1'b0;
            bus.out_unf   <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        mcand        <= bus.man_a;
                        prod         <= {{MW{1'b0}}, bus.man_b};
                        cnt          <= '0;
                        exp_sum      <= exp_in_c;
                        sign_r       <= bus.sign_a ^ bus.sign_b;
                        zero_r       <= (bus.exp_a == '0) || (bus.exp_b == '0);
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= MUL;
                    end
                end
                MUL: begin
                    prod <= {upper_c, prod[MW-1:1]};
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST_STEP) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    bus.out_sign <= sign_r;
                    bus.out_ovf  <= 1'b0;
                    bus.out_unf  <= 1'b0;
                    // Zero operand dominates, then overflow, then underflow.
                    if (zero_r) begin
                        bus.out_exp <= '0;
                        bus.out_man <= '0;
                    end else if (ovf_c) begin
                        bus.out_exp <= '1;
                        bus.out_man <= '0;
                        bus.out_ovf <= 1'b1;
                    end else if (unf_c) begin
                        bus.out_exp <= '0;
                        bus.out_man <= '0;
                        bus.out_unf <= 1'b1;
                    end else begin
                        bus.out_exp <= exp_norm_c[EW-1:0];
                        bus.out_man <= man_norm_c;
                    end
                    bus.out_valid <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpm_mant_mul_seq.sv
// Self-checking bench for fpm_mant_mul_seq: directed table, corner sequences,
// and random operands against an arithmetic reference model.
module tb_fpm_mant_mul_seq;
    localparam int unsigned MW = 24;
    localparam int unsigned EW = 8;
    localparam int LAT = 25;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    fpm_mant_mul_seq_if #(.MW(MW), .EW(EW)) bus ();

    fpm_mant_mul_seq #(.MW(MW), .EW(EW), .BIAS(127)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sa;
        logic        sb;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [23:0] ma;
        logic [23:0] mb;
        logic [33:0] expect_res;   // {sign, exp, man, ovf, unf}
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [33:0] pack_res(input logic s, input logic [7:0] e,
                                             input logic [22:0] m, input logic o, input logic u);
        return {s, e, m, o, u};
    endfunction

    // Reference: real integer multiply of the mantissas, then the result rules.
    function automatic logic [33:0] model(input logic sa, input logic sb, input logic [7:0] ea,
                                          input logic [7:0] eb, input logic [23:0] ma,
                                          input logic [23:0] mb);
        longint p;
        int     e;
        logic [22:0] m;
        logic s;
        s = sa ^ sb;
        p = longint'(ma) * longint'(mb);
        e = int'(ea) + int'(eb) - 127;
        if (p >= (longint'(1) << 47)) begin
            e = e + 1;
            m = 23'((p >> 24) & 64'h7F_FFFF);
        end else begin
            m = 23'((p >> 23) & 64'h7F_FFFF);
        end
        if (ea == 8'd0 || eb == 8'd0) return pack_res(s, 8'd0, 23'd0, 1'b0, 1'b0);
        if (e >= 255) return pack_res(s, 8'hFF, 23'd0, 1'b1, 1'b0);
        if (e <= 0) return pack_res(s, 8'd0, 23'd0, 1'b0, 1'b1);
        return pack_res(s, 8'(e), m, 1'b0, 1'b0);
    endfunction

    function automatic logic [33:0] dut_res();
        return {bus.out_sign, bus.out_exp, bus.out_man, bus.out_ovf, bus.out_unf};
    endfunction

    // Present operands for one cycle and wait (bounded) for out_valid.
    task automatic start_op(input logic sa, input logic sb, input logic [7:0] ea, input logic [7:0] eb,
                            input logic [23:0] ma, input logic [23:0] mb);
        int w;
        w = 0;
        while (!bus.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: got 0, want 1");
        end
        bus.sign_a   = sa;
        bus.sign_b   = sb;
        bus.exp_a    = ea;
        bus.exp_b    = eb;
        bus.man_a    = ma;
        bus.man_b    = mb;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) begin
            total++;
            bad++;
            $display("FAIL out_valid_timeout: got 0, want 1 after %0d cycles", lat);
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("hs_out_valid_low", 64'(bus.out_valid), 64'd0);
        chk("hs_in_ready_high", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic run_op(input string name, input logic sa, input logic sb, input logic [7:0] ea,
                          input logic [7:0] eb, input logic [23:0] ma, input logic [23:0] mb,
                          input logic [33:0] req, input logic check_lat);
        int lat;
        start_op(sa, sb, ea, eb, ma, mb);
        wait_valid(lat);
        if (check_lat) chk({name, "_latency"}, 64'(lat), 64'(LAT));
        chk(name, 64'(dut_res()), 64'(req));
        handshake();
    endtask

    initial begin
        logic [33:0] held;
        logic [33:0] r;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [23:0] ma;
        logic [23:0] mb;
        logic        sa;
        logic        sb;
        int          lat;

        total = 0;
        bad   = 0;
        vecs[0] = '{"mul_1p5x2", 1'b0, 1'b0, 8'd127, 8'd128, 24'hC00000, 24'h800000,
                    {1'b0, 8'd128, 23'h400000, 1'b0, 1'b0}};
        vecs[1] = '{"mul_1p5x1p5", 1'b0, 1'b0, 8'd127, 8'd127, 24'hC00000, 24'hC00000,
                    {1'b0, 8'd128, 23'h100000, 1'b0, 1'b0}};
        vecs[2] = '{"mul_m2x3", 1'b1, 1'b0, 8'd128, 8'd128, 24'h800000, 24'hC00000,
                    {1'b1, 8'd129, 23'h400000, 1'b0, 1'b0}};
        vecs[3] = '{"zero_a", 1'b0, 1'b0, 8'd0, 8'd129, 24'h000000, 24'hA00000,
                    {1'b0, 8'd0, 23'h000000, 1'b0, 1'b0}};
        vecs[4] = '{"overflow", 1'b0, 1'b0, 8'd254, 8'd128, 24'h800000, 24'h800000,
                    {1'b0, 8'hFF, 23'h000000, 1'b1, 1'b0}};
        vecs[5] = '{"underflow", 1'b0, 1'b0, 8'd1, 8'd1, 24'h800000, 24'h800000,
                    {1'b0, 8'd0, 23'h000000, 1'b0, 1'b1}};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.sign_a    = 1'b0;
        bus.sign_b    = 1'b0;
        bus.exp_a     = '0;
        bus.exp_b     = '0;
        bus.man_a     = '0;
        bus.man_b     = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'(dut_res()), 64'd0);
        chk("reset_valid_busy", 64'({bus.out_valid, bus.busy}), 64'd0);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].name, vecs[i].sa, vecs[i].sb, vecs[i].ea, vecs[i].eb,
                   vecs[i].ma, vecs[i].mb, vecs[i].expect_res, 1'b1);
        end

        // Backpressure: results held in DONE, new operands ignored meanwhile.
        start_op(1'b0, 1'b1, 8'd130, 8'd125, 24'hE00000, 24'hA00000);
        wait_valid(lat);
        held = dut_res();
        chk("bp_result", 64'(held), 64'(model(1'b0, 1'b1, 8'd130, 8'd125, 24'hE00000, 24'hA00000)));
        bus.in_valid = 1'b1;
        bus.exp_a    = 8'd100;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_hold_data", 64'(dut_res()), 64'(held));
            chk("bp_hold_flags", 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'b100);
        end
        bus.in_valid = 1'b0;
        handshake();
        run_op("bp_second", 1'b0, 1'b0, 8'd127, 8'd128, 24'hC00000, 24'h800000,
               {1'b0, 8'd128, 23'h400000, 1'b0, 1'b0}, 1'b1);

        // Reset in the middle of the multiply loop.
        start_op(1'b1, 1'b1, 8'd140, 8'd120, 24'hFFFFFF, 24'hFFFFFF);
        repeat (9) @(negedge clk);
        chk("midop_busy", 64'(bus.busy), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("midop_rst_outputs", 64'(dut_res()), 64'd0);
        chk("midop_rst_flags", 64'({bus.out_valid, bus.busy, bus.in_ready}), 64'b001);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("midop_no_output", 64'(bus.out_valid), 64'd0);
        run_op("after_rst", 1'b0, 1'b0, 8'd127, 8'd128, 24'hC00000, 24'h800000,
               {1'b0, 8'd128, 23'h400000, 1'b0, 1'b0}, 1'b1);

        // Random operands against the model, mixing near-limit exponents.
        for (int n = 0; n < 40; n++) begin
            sa = 1'($urandom);
            sb = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       ea = 8'($urandom);
                1:       ea = 8'($urandom_range(100, 154));
                2:       ea = 8'($urandom_range(190, 255));
                default: ea = 8'($urandom_range(0, 64));
            endcase
            eb = 8'($urandom_range(64, 192));
            if (n % 7 == 3) eb = 8'd0;
            ma = {1'b1, 23'($urandom)};
            mb = {1'b1, 23'($urandom)};
            r  = model(sa, sb, ea, eb, ma, mb);
            run_op("random", sa, sb, ea, eb, ma, mb, r, (n < 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
